// File: rtl/seq_fetch_ctrl.sv
// Fetch/issue controller for the 12-bit instruction sequencer: ROM fetch, run/step/breakpoint
// control, busy-based stalling of CMD/DMP instructions and retired-instruction counting.
module seq_fetch_ctrl #(
    parameter int AddrWidth  = 8,
    parameter int InstWidth  = 12,
    parameter int CountWidth = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  step,
    input  logic                  bp_en,
    input  logic [AddrWidth-1:0]  bp_addr,
    input  logic [AddrWidth-1:0]  seq_next,
    output logic [AddrWidth-1:0]  rom_addr,
    input  logic [InstWidth-1:0]  rom_data,
    input  logic [7:0]            busy,
    output logic [InstWidth-1:0]  inst,
    output logic                  inst_en,
    output logic [1:0]            state,
    output logic                  bp_hit,
    output logic [CountWidth-1:0] icount
);

    localparam logic [3:0] OpCmd   = 4'h3;
    localparam logic [3:0] OpDmp   = 4'h4;
    localparam logic [3:0] OpFault = 4'hB;

    // BPCHK is the second half of the pipelined fetch and reports itself as FETCH.
    typedef enum logic [2:0] {
        S_HALT  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_FAULT = 3'd3,
        S_BPCHK = 3'd4
    } fsm_e;

    fsm_e       cur_state, next_state;
    logic       step_q;
    logic       step_rise;
    logic       ss_flag, ss_next;
    logic       bp_hit_next;
    logic [3:0] opcode;
    logic       stall;
    logic       issue;

    assign opcode    = rom_data[11:8];
    assign step_rise = step & ~step_q;
    assign stall     = ((opcode == OpCmd) || (opcode == OpDmp)) && busy[rom_data[2:0]];
    assign issue     = (cur_state == S_ISSUE) && !stall;

    assign rom_addr = seq_next;
    assign inst     = (cur_state == S_ISSUE) ? rom_data : '0;
    assign inst_en  = issue;
    assign state    = (cur_state == S_BPCHK) ? 2'd1 : cur_state[1:0];

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        next_state  = cur_state;
        ss_next     = ss_flag;
        bp_hit_next = bp_hit;
        unique case (cur_state)
            S_HALT: begin
                if (!run) bp_hit_next = 1'b0;
                if (run && !bp_hit) begin
                    next_state = S_FETCH;
                end else if (step_rise) begin
                    next_state  = S_FETCH;
                    bp_hit_next = 1'b0;
                    ss_next     = 1'b1;
                end
            end
            S_FETCH: next_state = S_ISSUE;
            S_ISSUE: begin
                if (!stall) begin
                    if (opcode >= OpFault) begin
                        next_state = S_FAULT;
                    end else if (ss_flag || !run) begin
                        next_state = S_HALT;
                        ss_next    = 1'b0;
                    end else begin
                        next_state = S_BPCHK;
                    end
                end
            end
            // seq_next already points past the issued instruction, so the breakpoint is checked here.
            S_BPCHK: begin
                if (bp_en && (seq_next == bp_addr)) begin
                    bp_hit_next = 1'b1;
                    next_state  = S_HALT;
                end else begin
                    next_state = S_ISSUE;
                end
            end
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_HALT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_state <= S_HALT;
            step_q    <= 1'b0;
            ss_flag   <= 1'b0;
            bp_hit    <= 1'b0;
            icount    <= '0;
        end else begin
            cur_state <= next_state;
            step_q    <= step;
            ss_flag   <= ss_next;
            bp_hit    <= bp_hit_next;
            if (issue) icount <= icount + CountWidth'(1);
        end
    end

endmodule

// File: tb/tb_seq_fetch_ctrl.sv
// Bench for seq_fetch_ctrl: models the ROM and a minimal sequencer core, checks issued
// instructions through a scoreboard and control state through directed checks.
module tb_seq_fetch_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        bp_en = 1'b0;
    logic [7:0]  bp_addr = 8'h00;
    logic [7:0]  seq_next;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data = 12'h000;
    logic [7:0]  busy = 8'h00;
    logic [11:0] inst;
    logic        inst_en;
    logic [1:0]  state;
    logic        bp_hit;
    logic [15:0] icount;

    logic [11:0] rom [256];
    logic [7:0]  pc;

    typedef struct {
        logic [11:0] inst;
        logic [7:0]  addr;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    seq_fetch_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .run      (run),
        .step     (step),
        .bp_en    (bp_en),
        .bp_addr  (bp_addr),
        .seq_next (seq_next),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy),
        .inst     (inst),
        .inst_en  (inst_en),
        .state    (state),
        .bp_hit   (bp_hit),
        .icount   (icount)
    );

    always #5 clock = ~clock;

    // Synchronous ROM with one-cycle latency.
    always @(posedge clock) rom_data <= rom[rom_addr];

    // Core model: JXI (opcode 7) jumps to the immediate, everything else advances by one.
    always @(posedge clock or negedge reset) begin
        if (!reset) pc <= 8'h00;
        else if (inst_en) pc <= (inst[11:8] == 4'h7) ? inst[7:0] : pc + 8'd1;
    end
    assign seq_next = pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every issue must match the oldest expected instruction.
    always @(negedge clock) begin
        if (reset && inst_en) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got inst 0x%0h at addr 0x%0h, expected none at %0t",
                         inst, rom_addr, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("issue_inst", 32'(inst), 32'(e.inst));
                check("issue_addr", 32'(rom_addr), 32'(e.addr));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_issue(input logic [11:0] i, input logic [7:0] a);
        exp_t e;
        e.inst = i;
        e.addr = a;
        sb.push_back(e);
    endtask

    task automatic wait_state(input logic [1:0] tgt, input int max, input string name);
        int n = 0;
        while (state != tgt && n < max) begin
            tick();
            n++;
        end
        check(name, 32'(state), 32'(tgt));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        run   = 1'b0;
        step  = 1'b0;
        busy  = 8'h00;
        bp_en = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        reset = 1'b0;
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_inst_en", 32'(inst_en), 0);
        check("rst_inst", 32'(inst), 0);
        check("rst_icount", 32'(icount), 0);
        check("rst_bp_hit", 32'(bp_hit), 0);
        tick();
        reset = 1'b1;

        // 1: free run, 2 cycles per instruction, JXI loops back
        rom[0] = 12'h105;
        rom[1] = 12'h000;
        rom[2] = 12'h700;
        expect_issue(12'h105, 8'h00);
        expect_issue(12'h000, 8'h01);
        expect_issue(12'h700, 8'h02);
        run = 1'b1;
        tick();
        check("t1_fetch", 32'(state), 1);
        check("t1_rom_addr", 32'(rom_addr), 0);
        tick();
        check("t1_issue", 32'(state), 2);
        check("t1_inst_en", 32'(inst_en), 1);
        tick();
        check("t1_bpchk_enc", 32'(state), 1);
        check("t1_no_en", 32'(inst_en), 0);
        repeat (4) tick();
        check("t1_icount3", 32'(icount), 3);
        check("t1_sb_empty", 32'(sb.size()), 0);
        // run falls mid-instruction: the fetched instruction still issues
        expect_issue(12'h105, 8'h00);
        run = 1'b0;
        wait_state(2'd0, 10, "t1_halt");
        check("t1_icount4", 32'(icount), 4);

        // 2: CMD stall on busy destination
        do_reset();
        rom[0] = 12'h3A2;
        rom[1] = 12'h1A3;
        busy = 8'h04;
        run = 1'b1;
        expect_issue(12'h3A2, 8'h00);
        expect_issue(12'h1A3, 8'h01);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_stall_state", 32'(state), 2);
            check("t2_stall_en", 32'(inst_en), 0);
        end
        tick();
        busy = 8'h08;
        #1;
        check("t2_release_en", 32'(inst_en), 1);
        check("t2_release_inst", 32'(inst), 32'h3A2);
        tick();
        run = 1'b0;
        tick();
        check("t2_non_cmd_en", 32'(inst_en), 1);
        tick();
        check("t2_halt", 32'(state), 0);
        check("t2_icount", 32'(icount), 2);

        // 3: single step
        do_reset();
        rom[0] = 12'h105;
        rom[1] = 12'h200;
        rom[2] = 12'h000;
        for (int k = 0; k < 3; k++) begin
            expect_issue(rom[k], 8'(k));
            step = 1'b1;
            tick();
            step = 1'b0;
            check("t3_fetch", 32'(state), 1);
            tick();
            check("t3_issue_en", 32'(inst_en), 1);
            if (k == 1) step = 1'b1;
            tick();
            check("t3_halt", 32'(state), 0);
            tick();
            tick();
            check("t3_stay_halt", 32'(state), 0);
            step = 1'b0;
            tick();
        end
        check("t3_icount", 32'(icount), 3);
        check("t3_sb_empty", 32'(sb.size()), 0);

        // 4: breakpoint
        do_reset();
        bp_en = 1'b1;
        bp_addr = 8'h02;
        expect_issue(12'h000, 8'h00);
        expect_issue(12'h000, 8'h01);
        run = 1'b1;
        tick();
        wait_state(2'd0, 20, "t4_bp_halt");
        check("t4_bp_hit", 32'(bp_hit), 1);
        check("t4_icount", 32'(icount), 2);
        check("t4_addr", 32'(rom_addr), 2);
        repeat (4) tick();
        check("t4_hold_state", 32'(state), 0);
        check("t4_hold_bp", 32'(bp_hit), 1);
        expect_issue(12'h000, 8'h02);
        run = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        check("t4_bp_clr", 32'(bp_hit), 0);
        wait_state(2'd0, 10, "t4_step_halt");
        check("t4_icount_step", 32'(icount), 3);
        expect_issue(12'h000, 8'h03);
        expect_issue(12'h000, 8'h04);
        run = 1'b1;
        repeat (3) tick();
        run = 1'b0;
        wait_state(2'd0, 10, "t4_resume_halt");
        check("t4_icount_resume", 32'(icount), 5);

        // 5: illegal opcode faults and sticks
        do_reset();
        rom[1] = 12'hB00;
        expect_issue(12'h000, 8'h00);
        expect_issue(12'hB00, 8'h01);
        run = 1'b1;
        tick();
        wait_state(2'd3, 20, "t5_fault");
        check("t5_icount", 32'(icount), 2);
        begin
            int bad = 0;
            for (int i = 0; i < 10; i++) begin
                run  = i[0];
                step = i[1];
                tick();
                if (state != 2'd3 || inst_en) bad++;
            end
            check("t5_fault_sticky", 32'(bad), 0);
        end
        reset = 1'b0;
        #1;
        check("t5_rst_state", 32'(state), 0);
        check("t5_rst_icount", 32'(icount), 0);

        // 6: asynchronous reset mid-stall
        do_reset();
        rom[1] = 12'h3A2;
        busy = 8'h04;
        expect_issue(12'h000, 8'h00);
        run = 1'b1;
        repeat (6) tick();
        check("t6_stalled", 32'(state), 2);
        check("t6_icount", 32'(icount), 1);
        @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("t6_async_en", 32'(inst_en), 0);
        check("t6_async_state", 32'(state), 0);
        check("t6_async_icount", 32'(icount), 0);
        tick();
        run = 1'b0;
        busy = 8'h00;
        reset = 1'b1;
        tick();

        check("final_sb_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
